// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first magnitude compare of two WIDTH-bit operands, STEP bits per clock, early exit
// Ports: clock/reset_n (async active-low); start/abort/signed_mode/a/b request inputs;
//        busy (SCAN), done (one-cycle pulse), a_gt_b/a_lt_b/a_eq_b registered result flags held until next accept
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);
  localparam int NG = WIDTH / STEP;
  localparam int CW = NG > 1 ? $clog2(NG) : 1;
  localparam logic [WIDTH-1:0] MSB_M = WIDTH'(1) << (WIDTH - 1);
  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || WIDTH % STEP != 0) begin : g_bad_params
    $error("seq_magnitude_comparator: illegal WIDTH/STEP");
  end
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [STEP-1:0] ga, gb;
  logic last, diff;
  assign ga   = sa_q[WIDTH-1 -: STEP];
  assign gb   = sb_q[WIDTH-1 -: STEP];
  assign diff = ga != gb;
  assign last = cnt_q == CW'(NG - 1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SCAN : IDLE;
      SCAN:    state_d = abort ? IDLE : (diff || last) ? DONE : SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy   = state_q == SCAN;
    done   = state_q == DONE;
    a_gt_b = gt_q;
    a_lt_b = lt_q;
    a_eq_b = eq_q;
  end
  // Flipping the MSB maps two's complement onto offset binary, so the scan is always unsigned.
  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    cnt_d = cnt_q;
    gt_d  = gt_q;
    lt_d  = lt_q;
    eq_d  = eq_q;
    if (state_q == IDLE && start) begin
      sa_d  = signed_mode ? a ^ MSB_M : a;
      sb_d  = signed_mode ? b ^ MSB_M : b;
      cnt_d = '0;
      gt_d  = 1'b0;
      lt_d  = 1'b0;
      eq_d  = 1'b0;
    end else if (state_q == SCAN && !abort) begin
      if (diff) begin
        gt_d = ga > gb;
        lt_d = ga < gb;
      end else if (last) begin
        eq_d = 1'b1;
      end else begin
        sa_d  = sa_q << STEP;
        sb_d  = sb_q << STEP;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      cnt_q <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
      eq_q  <= eq_d;
    end
  end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: randomized self-checking bench against an arithmetic reference model
module tb_seq_magnitude_comparator;
  localparam int W  = 8;
  localparam int ST = 2;
  localparam int NG = W / ST;
  logic clock, reset_n, start, abort, signed_mode;
  logic [W-1:0] a, b;
  logic busy, done, a_gt_b, a_lt_b, a_eq_b;
  int n_chk = 0;
  int n_err = 0;
  seq_magnitude_comparator #(.WIDTH(W), .STEP(ST)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .signed_mode(signed_mode), .a(a), .b(b), .busy(busy), .done(done),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_idle0(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_gt"}, a_gt_b, 0);
    chk({tag, "_lt"}, a_lt_b, 0);
    chk({tag, "_eq"}, a_eq_b, 0);
  endtask
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                         input bit mid_start, input bit ab_idle);
    int g, n;
    bit found, eg, el, ee;
    if (ts) begin
      eg = $signed(ta) > $signed(tbv);
      el = $signed(ta) < $signed(tbv);
    end else begin
      eg = ta > tbv;
      el = ta < tbv;
    end
    ee = ta == tbv;
    g = NG - 1;
    found = 0;
    for (int i = W - 1; i >= 0; i--)
      if (!found && ta[i] != tbv[i]) begin
        found = 1;
        g = (W - 1 - i) / ST;
      end
    a = ta;
    b = tbv;
    signed_mode = ts;
    start = 1'b1;
    abort = ab_idle;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = 1'($urandom);
    chk("busy_accept", busy, 1);
    chk("flags_clear", {a_gt_b, a_lt_b, a_eq_b}, 0);
    if (mid_start) start = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      if (!done) chk("busy_scan", busy, 1);
    end
    chk("latency", n, g + 1);
    chk("busy_in_done", busy, 0);
    chk("gt", a_gt_b, eg);
    chk("lt", a_lt_b, el);
    chk("eq", a_eq_b, ee);
    abort = 1'($urandom);
    @(posedge clock); #1;
    abort = 1'b0;
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    chk("hold_flags", {a_gt_b, a_lt_b, a_eq_b}, {eg, el, ee});
  endtask
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_idle0("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_cmp(8'hA5, 8'hA5, 1'b0, 0, 0);
    run_cmp(8'h80, 8'h7F, 1'b0, 0, 0);
    run_cmp(8'h80, 8'h7F, 1'b1, 0, 0);
    run_cmp(8'h03, 8'h02, 1'b0, 1, 0);
    run_cmp(8'h12, 8'h34, 1'b1, 0, 1);
    a = 8'hA5;
    b = 8'hA5;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk_idle0("abort");
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clock); #1;
        seen += int'(done);
      end
      chk("abort_no_done", seen, 0);
    end
    run_cmp(8'h40, 8'h41, 1'b0, 0, 0);
    a = 8'hA5;
    b = 8'hA5;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk_idle0("async_rst");
    #10;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_cmp(8'hFF, 8'h01, 1'b1, 0, 0);
    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] ra, rb;
      int mode;
      ra = W'($urandom);
      mode = int'($urandom_range(0, 3));
      rb = mode == 0 ? ra : mode == 1 ? ra ^ (W'(1) << $urandom_range(0, W - 1)) : W'($urandom);
      run_cmp(ra, rb, 1'($urandom), bit'($urandom), bit'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
